branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised successor to the fetch-stage branch target buffer.
- Direct-mapped BTB with per-entry saturating direction counters, tagged lookup, and an optional return address stack (RAS).
- Sits beside the PC register: the fetch stage looks it up combinationally every cycle; the decode stage updates it once per resolved branch.
- Differs from the previous block in three ways: it trains on every resolved branch (not only mispredicts), it has hysteresis, and it predicts return targets.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB entries; power of 2, ≥2; IDX_W = log2(ENTRIES).
- TAG_W, 10, tag bits taken from PC[IDX_W+TAG_W+1 : IDX_W+2].
- CTR_W, 2, direction counter width, ≥1.
- RAS_DEPTH, 4, RAS entries; 0 removes the RAS (return hits use the stored target).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- PCF  in  XLEN  fetch PC (lookup address).
- BranchF  in  1  fetched instruction is a branch.
- PredictionF  out  1  predict taken.
- PredictedTarget  out  XLEN  predicted target; 0 when PredictionF=0.
- UpdateEnable  in  1  a branch resolved in decode this cycle.
- PCUpdate  in  XLEN  PC of the resolved branch.
- BranchTaken  in  1  resolved direction.
- PCBranch  in  XLEN  resolved target.
- UpdateCall  in  1  resolved branch is a call (BL).
- UpdateReturn  in  1  resolved branch is a return (target = LR).

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[XLEN], ctr[CTR_W], is_ret. RAS: circular stack of XLEN words, top pointer, count 0..RAS_DEPTH.
- Reset (reset=0, asynchronous):
  - all valid=0, ctr=0, is_ret=0, RAS count=0, pointer=0;
  - PredictionF=0 and PredictedTarget=0 while reset is held and afterwards until an entry is allocated.
  - Target words need no reset. Reset asserted mid-update drops that update.
- Lookup (combinational from registered state, 0-cycle latency):
  - idx = PCF[IDX_W+1:2]; hit = valid & tag match.
  - PredictionF = BranchF & hit & ctr[CTR_W-1].
  - PredictedTarget:
    - if PredictionF=0: 0;
    - else if is_ret & RAS count>0: RAS top;
    - else: stored target.
- Update (on the clk edge when UpdateEnable=1), using PCUpdate index/tag:
  - Hit, taken:
    - ctr = min(ctr+1, 2^CTR_W-1); target=PCBranch; is_ret=UpdateReturn.
  - Hit, not taken:
    - ctr = max(ctr-1, 0); entry stays valid.
  - Miss, taken (allocate, evicting any occupant):
    - valid=1, tag written, target=PCBranch, is_ret=UpdateReturn, ctr=2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change.
- RAS (only on UpdateEnable & BranchTaken):
  - UpdateCall alone: push PCUpdate+4.
    - When full, overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
  - UpdateReturn alone: pop. Pop when empty is a no-op; count stays 0.
  - Both asserted: replace top with PCUpdate+4, count unchanged; if empty, behave as push.
- Simultaneous lookup and update to the same index: the lookup sees pre-update contents; the new state is visible the next cycle. Same rule applies to RAS top.
- Inputs on UpdateEnable=0 cycles are don't-care.
- Widths:
  - counters saturate, never wrap;
  - PCUpdate+4 is modulo 2^XLEN;
  - PC[1:0] are ignored.

Decomposition:
- Shared package bp_pkg:
  - btb_entry_t struct (valid, tag, target, ctr, is_ret);
  - derived localparams IDX_W, CTR_MAX, CTR_WEAK_T;
  - index/tag extraction functions.
- One natural sub-module: return_stack (parametrised depth/width, push/pop/replace, top, count). It is generated only when RAS_DEPTH>0.

Test Plan:
1. Reset low for 3 cycles, then PCF=0x100 with BranchF=1 → PredictionF=0, PredictedTarget=0; assert reset low mid-stream while an entry is valid → entry is cleared immediately.
2. Update PCUpdate=0x100, taken, PCBranch=0x200; next cycle lookup 0x100 → PredictionF=1, target 0x200. One not-taken update → ctr=01, PredictionF=0. Two taken updates → ctr=11. One not-taken update → still predicted taken (hysteresis).
3. Alias: ENTRIES=64, allocate 0x100, then taken-update PCUpdate=0x100+(64<<2)=0x200 → lookup 0x100 misses, 0x200 hits. A not-taken update at miss PC 0x300 → no allocation.
4. RAS: calls at 0x1000 and 0x2000 (taken, UpdateCall), then return entry allocated at 0x3000 with UpdateReturn → lookup 0x3000 yields 0x2004. Pop once → yields 0x1004. Pop when empty → count=0, stored target used.
5. RAS overflow with depth 4: 5 pushes (0x10..0x50 +4) → count=4; pops return 0x54, 0x44, 0x34, 0x24, then the stack is empty.
6. Same-cycle update and lookup of 0x100 (allocate) → PredictionF=0 that cycle, 1 the next; ctr at 11 plus a taken update stays 11; ctr at 00 plus a not-taken update stays 00.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//
// Holds the default configuration, the quantities derived from it, the BTB
// entry layout, and PC field extraction helpers for that configuration.
// Parametrised instances derive their own widths with idx_width().
package bp_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned ENTRIES_DEF   = 64;
    localparam int unsigned TAG_W_DEF     = 10;
    localparam int unsigned CTR_W_DEF     = 2;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    localparam int unsigned IDX_W      = $clog2(ENTRIES_DEF);
    localparam int unsigned CTR_MAX    = (1 << CTR_W_DEF) - 1;
    // New allocations start weakly taken: MSB set, all other bits clear.
    localparam int unsigned CTR_WEAK_T = 1 << (CTR_W_DEF - 1);

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  target;
        logic [CTR_W_DEF-1:0] ctr;
        logic                 is_ret;
    } btb_entry_t;

    // Index width for a table of the given size (at least one bit).
    function automatic int unsigned idx_width(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // Word-aligned index: PC[1:0] never take part.
    function automatic logic [IDX_W-1:0] pc_index(input logic [XLEN_DEF-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W_DEF-1:0] pc_tag(input logic [XLEN_DEF-1:0] pc);
        return pc[IDX_W+TAG_W_DEF+1:IDX_W+2];
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return address stack.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : push data_i
//   pop_i         : pop the top entry (no-op when empty)
//   push_i&pop_i  : replace the top with data_i; acts as a push when empty
//   data_i        : word to push/replace
//   top_o         : current top of stack (meaningless when count_o == 0)
//   count_o       : number of live entries, saturating at Depth
module return_stack #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] top_o,
    output logic [CntW-1:0]  count_o
);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    // ptr_q is the next free slot; the top lives one below it.
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  top_ptr, nxt_ptr, wr_ptr;
    logic             wr_en;

    assign top_ptr = (ptr_q == '0) ? PtrLast : ptr_q - PtrW'(1);
    assign nxt_ptr = (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = ptr_q;
        if (push_i && (!pop_i || count_q == '0)) begin
            // When full, the write slot wraps onto the oldest entry.
            wr_en = 1'b1;
            ptr_d = nxt_ptr;
            if (count_q != CntFull) begin
                count_d = count_q + CntW'(1);
            end
        end else if (push_i && pop_i) begin
            wr_en  = 1'b1;
            wr_ptr = top_ptr;
        end else if (pop_i && count_q != '0) begin
            ptr_d   = top_ptr;
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

    assign top_o   = mem_q[top_ptr];
    assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped tagged BTB with per-entry
// saturating direction counters and an optional return address stack.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   PCF, BranchF          : fetch lookup address / fetched insn is a branch
//   PredictionF           : predict taken (combinational, same cycle)
//   PredictedTarget       : predicted target, 0 when not predicting taken
//   UpdateEnable          : a branch resolved in decode this cycle
//   PCUpdate, BranchTaken : resolved branch PC and direction
//   PCBranch              : resolved target
//   UpdateCall/Return     : resolved branch is a call / a return
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned ENTRIES   = ENTRIES_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned CTR_W     = CTR_W_DEF,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    input  logic            BranchF,
    output logic            PredictionF,
    output logic [XLEN-1:0] PredictedTarget,
    input  logic            UpdateEnable,
    input  logic [XLEN-1:0] PCUpdate,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] PCBranch,
    input  logic            UpdateCall,
    input  logic            UpdateReturn
);

    localparam int unsigned     IdxW     = idx_width(ENTRIES);
    localparam int unsigned     TagLo    = IdxW + 2;
    localparam int unsigned     TagHi    = IdxW + TAG_W + 1;
    localparam logic [CTR_W-1:0] CtrMax   = '1;
    localparam logic [CTR_W-1:0] CtrWeakT = CTR_W'(1) << (CTR_W - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CTR_W-1:0] ctr;
        logic             is_ret;
    } entry_t;

    // Control fields are reset; tags and targets are qualified by valid.
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] is_ret_q;
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic            ras_push, ras_pop, ras_valid;
    logic [XLEN-1:0] ras_top, ret_addr;

    // ---------------------------------------------------------------- lookup
    logic [IdxW-1:0]  idx_f;
    logic [TAG_W-1:0] tag_f;
    entry_t           ent_f;
    logic             hit_f;

    assign idx_f = PCF[IdxW+1:2];
    assign tag_f = PCF[TagHi:TagLo];

    always_comb begin
        ent_f        = '0;
        ent_f.valid  = valid_q[idx_f];
        ent_f.tag    = tag_q[idx_f];
        ent_f.target = target_q[idx_f];
        ent_f.ctr    = ctr_q[idx_f];
        ent_f.is_ret = is_ret_q[idx_f];
    end

    assign hit_f       = ent_f.valid && (ent_f.tag == tag_f);
    assign PredictionF = BranchF & hit_f & ent_f.ctr[CTR_W-1];

    always_comb begin
        PredictedTarget = '0;
        if (PredictionF) begin
            PredictedTarget = (ent_f.is_ret && ras_valid) ? ras_top : ent_f.target;
        end
    end

    // ---------------------------------------------------------------- update
    logic [IdxW-1:0]  idx_u;
    logic [TAG_W-1:0] tag_u;
    logic             hit_u;
    logic [CTR_W-1:0] ctr_u, ctr_d;
    logic             is_ret_d;
    logic             ent_we, tgt_we;

    assign idx_u = PCUpdate[IdxW+1:2];
    assign tag_u = PCUpdate[TagHi:TagLo];
    assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    assign ctr_u = ctr_q[idx_u];

    always_comb begin
        ent_we   = 1'b0;
        tgt_we   = 1'b0;
        ctr_d    = ctr_u;
        is_ret_d = is_ret_q[idx_u];
        if (UpdateEnable) begin
            if (hit_u) begin
                ent_we = 1'b1;
                if (BranchTaken) begin
                    tgt_we   = 1'b1;
                    is_ret_d = UpdateReturn;
                    ctr_d    = (ctr_u == CtrMax) ? ctr_u : ctr_u + CTR_W'(1);
                end else begin
                    ctr_d = (ctr_u == '0) ? ctr_u : ctr_u - CTR_W'(1);
                end
            end else if (BranchTaken) begin
                // Allocate, evicting whatever aliased into this slot.
                ent_we   = 1'b1;
                tgt_we   = 1'b1;
                is_ret_d = UpdateReturn;
                ctr_d    = CtrWeakT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            is_ret_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= '0;
            end
        end else if (ent_we) begin
            valid_q[idx_u]  <= 1'b1;
            is_ret_q[idx_u] <= is_ret_d;
            ctr_q[idx_u]    <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tgt_we) begin
            tag_q[idx_u]    <= tag_u;
            target_q[idx_u] <= PCBranch;
        end
    end

    // ------------------------------------------------------------------- RAS
    assign ret_addr = PCUpdate + XLEN'(4);
    assign ras_push = UpdateEnable & BranchTaken & UpdateCall;
    assign ras_pop  = UpdateEnable & BranchTaken & UpdateReturn;

    if (RAS_DEPTH > 0) begin : g_ras
        localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
        logic [CntW-1:0] ras_count;

        return_stack #(
            .Depth (RAS_DEPTH),
            .Width (XLEN)
        ) u_ras (
            .clk_i   (clk),
            .rst_ni  (reset),
            .push_i  (ras_push),
            .pop_i   (ras_pop),
            .data_i  (ret_addr),
            .top_o   (ras_top),
            .count_o (ras_count)
        );

        assign ras_valid = (ras_count != '0);
    end else begin : g_no_ras
        assign ras_top   = '0;
        assign ras_valid = 1'b0;
    end

    // PC bits outside index/tag play no part in prediction.
    logic unused_bits;
    assign unused_bits = ^{PCF[1:0], PCF[XLEN-1:TagHi+1], ras_push, ras_pop, ret_addr,
                           UpdateCall};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        BranchF;
    logic        PredictionF;
    logic [31:0] PredictedTarget;
    logic        UpdateEnable;
    logic [31:0] PCUpdate;
    logic        BranchTaken;
    logic [31:0] PCBranch;
    logic        UpdateCall;
    logic        UpdateReturn;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN      (32),
        .ENTRIES   (64),
        .TAG_W     (10),
        .CTR_W     (2),
        .RAS_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .PCF             (PCF),
        .BranchF         (BranchF),
        .PredictionF     (PredictionF),
        .PredictedTarget (PredictedTarget),
        .UpdateEnable    (UpdateEnable),
        .PCUpdate        (PCUpdate),
        .BranchTaken     (BranchTaken),
        .PCBranch        (PCBranch),
        .UpdateCall      (UpdateCall),
        .UpdateReturn    (UpdateReturn)
    );

    typedef struct packed {
        logic        pred;
        logic [31:0] tgt;
    } exp_t;

    typedef struct packed {
        logic        do_upd;
        logic [31:0] upc;
        logic        taken;
        logic [31:0] utgt;
        logic        is_call;
        logic        is_ret;
        logic [31:0] lpc;
        logic        bf;
        logic        epred;
        logic [31:0] etgt;
    } step_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic step_t mk(input logic du, input logic [31:0] upc, input logic tk,
                                 input logic [31:0] utgt, input logic c, input logic r,
                                 input logic [31:0] lpc, input logic bf, input logic ep,
                                 input logic [31:0] et);
        step_t s;
        s = '{du, upc, tk, utgt, c, r, lpc, bf, ep, et};
        return s;
    endfunction

    task automatic apply_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input logic c, input logic r);
        @(negedge clk);
        UpdateEnable = 1'b1;
        PCUpdate     = pc;
        BranchTaken  = tk;
        PCBranch     = tgt;
        UpdateCall   = c;
        UpdateReturn = r;
        @(posedge clk);
        #1;
        UpdateEnable = 1'b0;
        BranchTaken  = 1'b0;
        UpdateCall   = 1'b0;
        UpdateReturn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset   = 1'b0;
        PCF     = 32'h100;
        BranchF = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back('{1'b0, 32'h0});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL reset_held: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        @(negedge clk); reset = 1'b1; #1;
        sb_q.push_back('{1'b0, 32'h0});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL after_reset: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        apply_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        @(negedge clk); PCF = 32'h100; #1;
        sb_q.push_back('{1'b1, 32'h200});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL alloc_pre_reset: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        // Reset mid-stream with an update pending: entry clears at once, update dropped.
        @(negedge clk);
        UpdateEnable = 1'b1; PCUpdate = 32'h104; BranchTaken = 1'b1; PCBranch = 32'h300;
        #2; reset = 1'b0; #1;
        sb_q.push_back('{1'b0, 32'h0});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL async_clear: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        @(posedge clk); #1;
        UpdateEnable = 1'b0; BranchTaken = 1'b0;
        @(negedge clk); reset = 1'b1; #1;
        sb_q.push_back('{1'b0, 32'h0});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL cleared_entry: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        PCF = 32'h104; #1;
        sb_q.push_back('{1'b0, 32'h0});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL dropped_update: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
    endtask

    task automatic test_hysteresis();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200));
        s.push_back(mk(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0));
        s.push_back(mk(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200));
        s.push_back(mk(1'b1, 32'h100, 1'b1, 32'h280, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h280));
        s.push_back(mk(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h280));
        s.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0));
        s.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 32'h0));
        foreach (s[i]) begin
            if (s[i].do_upd) apply_update(s[i].upc, s[i].taken, s[i].utgt, s[i].is_call, s[i].is_ret);
            @(negedge clk); PCF = s[i].lpc; BranchF = s[i].bf;
            sb_q.push_back('{s[i].epred, s[i].etgt});
            #1; e = sb_q.pop_front(); n_checks++;
            if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
                n_fail++;
                $display("FAIL hysteresis[%0d]: got pred=%b tgt=%h, want pred=%b tgt=%h",
                         i, PredictionF, PredictedTarget, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_alias();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200));
        s.push_back(mk(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0));
        s.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 32'h300));
        s.push_back(mk(1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 32'h0));
        s.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 32'h300));
        s.push_back(mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h203, 1'b1, 1'b1, 32'h300));
        foreach (s[i]) begin
            if (s[i].do_upd) apply_update(s[i].upc, s[i].taken, s[i].utgt, s[i].is_call, s[i].is_ret);
            @(negedge clk); PCF = s[i].lpc; BranchF = s[i].bf;
            sb_q.push_back('{s[i].epred, s[i].etgt});
            #1; e = sb_q.pop_front(); n_checks++;
            if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
                n_fail++;
                $display("FAIL alias[%0d]: got pred=%b tgt=%h, want pred=%b tgt=%h",
                         i, PredictionF, PredictedTarget, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_ras();
        step_t s[$];
        exp_t  e;
        do_reset();
        // Return entry sits at index 2; the call PCs all alias to index 0.
        s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'h9990, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h9990));
        s.push_back(mk(1'b1, 32'h1000, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h1004));
        s.push_back(mk(1'b1, 32'h2000, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h2004));
        s.push_back(mk(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h2000, 1'b1, 1'b1, 32'h5000));
        s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'h9990, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h1004));
        s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'h9990, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h9990));
        s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'h9990, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h9990));
        s.push_back(mk(1'b1, 32'h4000, 1'b1, 32'h5000, 1'b1, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h4004));
        s.push_back(mk(1'b1, 32'h1000, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h1004));
        s.push_back(mk(1'b1, 32'h6000, 1'b1, 32'h5000, 1'b1, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h6004));
        s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'h9990, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h4004));
        s.push_back(mk(1'b1, 32'h1000, 1'b0, 32'h5000, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h4004));
        foreach (s[i]) begin
            if (s[i].do_upd) apply_update(s[i].upc, s[i].taken, s[i].utgt, s[i].is_call, s[i].is_ret);
            @(negedge clk); PCF = s[i].lpc; BranchF = s[i].bf;
            sb_q.push_back('{s[i].epred, s[i].etgt});
            #1; e = sb_q.pop_front(); n_checks++;
            if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
                n_fail++;
                $display("FAIL ras[%0d]: got pred=%b tgt=%h, want pred=%b tgt=%h",
                         i, PredictionF, PredictedTarget, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_ras_overflow();
        step_t       s[$];
        exp_t        e;
        logic [31:0] pc;
        logic [31:0] top;
        do_reset();
        s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'hABC0, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'hABC0));
        for (int k = 1; k <= 5; k++) begin
            pc = 32'(k) << 4;
            s.push_back(mk(1'b1, pc, 1'b1, 32'h8000, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, pc + 32'h4));
        end
        // Oldest (0x14) was overwritten; pops walk back to 0x24, then the stack is empty.
        for (int k = 4; k >= 1; k--) begin
            top = (k > 1) ? ((32'(k) << 4) + 32'h4) : 32'hABC0;
            s.push_back(mk(1'b1, 32'h3008, 1'b1, 32'hABC0, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, top));
        end
        foreach (s[i]) begin
            if (s[i].do_upd) apply_update(s[i].upc, s[i].taken, s[i].utgt, s[i].is_call, s[i].is_ret);
            @(negedge clk); PCF = s[i].lpc; BranchF = s[i].bf;
            sb_q.push_back('{s[i].epred, s[i].etgt});
            #1; e = sb_q.pop_front(); n_checks++;
            if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
                n_fail++;
                $display("FAIL ras_overflow[%0d]: got pred=%b tgt=%h, want pred=%b tgt=%h",
                         i, PredictionF, PredictedTarget, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        do_reset();
        @(negedge clk);
        UpdateEnable = 1'b1; PCUpdate = 32'h100; BranchTaken = 1'b1; PCBranch = 32'h200;
        PCF = 32'h100; BranchF = 1'b1;
        sb_q.push_back('{1'b0, 32'h0});
        #1; e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL same_cycle_btb: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        @(posedge clk); #1;
        UpdateEnable = 1'b0; BranchTaken = 1'b0;
        sb_q.push_back('{1'b1, 32'h200});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL next_cycle_btb: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        apply_update(32'h3008, 1'b1, 32'hABC0, 1'b0, 1'b1);
        @(negedge clk);
        UpdateEnable = 1'b1; PCUpdate = 32'h10; BranchTaken = 1'b1; PCBranch = 32'h8000;
        UpdateCall = 1'b1; PCF = 32'h3008;
        sb_q.push_back('{1'b1, 32'hABC0});
        #1; e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL same_cycle_ras: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
        @(posedge clk); #1;
        UpdateEnable = 1'b0; BranchTaken = 1'b0; UpdateCall = 1'b0;
        sb_q.push_back('{1'b1, 32'h14});
        e = sb_q.pop_front(); n_checks++;
        if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
            n_fail++;
            $display("FAIL next_cycle_ras: got pred=%b tgt=%h, want pred=%b tgt=%h",
                     PredictionF, PredictedTarget, e.pred, e.tgt);
        end
    endtask

    task automatic test_saturation();
        step_t s[$];
        exp_t  e;
        logic  tk [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        // Counter path: 10 11 11 10 01 00 00 01 10
        logic  ep [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            s.push_back(mk(1'b1, 32'h100, tk[k], 32'h200, 1'b0, 1'b0, 32'h100, 1'b1, ep[k],
                           ep[k] ? 32'h200 : 32'h0));
        end
        foreach (s[i]) begin
            if (s[i].do_upd) apply_update(s[i].upc, s[i].taken, s[i].utgt, s[i].is_call, s[i].is_ret);
            @(negedge clk); PCF = s[i].lpc; BranchF = s[i].bf;
            sb_q.push_back('{s[i].epred, s[i].etgt});
            #1; e = sb_q.pop_front(); n_checks++;
            if (PredictionF !== e.pred || PredictedTarget !== e.tgt) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got pred=%b tgt=%h, want pred=%b tgt=%h",
                         i, PredictionF, PredictedTarget, e.pred, e.tgt);
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        PCF          = 32'h0;
        BranchF      = 1'b0;
        UpdateEnable = 1'b0;
        PCUpdate     = 32'h0;
        BranchTaken  = 1'b0;
        PCBranch     = 32'h0;
        UpdateCall   = 1'b0;
        UpdateReturn = 1'b0;
        test_reset();
        test_hysteresis();
        test_alias();
        test_ras();
        test_ras_overflow();
        test_same_cycle();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, want completion",
                 n_checks);
        $fatal(1);
    end

endmodule
